// File: rtl/acc_fetch_sequencer.sv
// rtl/acc_fetch_sequencer.sv - fetch/decode/execute sequencer for the 8-bit accumulator datapath
//
// Reads instruction and operand bytes from program memory and hands one
// decoded ALU/LOAD/STORE operation per transfer to the datapath. JUMP, HALT
// and NOP are resolved here and never reach the datapath.
//
// Optional build macro SEQ_STEP_EN: adds the step input and a PAUSE state.
// The block pauses after every transfer, JUMP and NOP, and resumes on step or start.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   start                  begin/resume from IDLE or HALT (and PAUSE when stepping)
//   step                   SEQ_STEP_EN only: leave PAUSE
//   mem_req, mem_addr      read request, held with a stable address until mem_ack
//   mem_ack, mem_rdata     read completion, data valid in the same cycle
//   exec_valid, dp_ready   datapath handshake, transfer when both are high
//   instr_out, operand_out decoded instruction/operand, stable while exec_valid
//   pc                     program counter
//   busy, halted, fault    status flags
module acc_fetch_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef SEQ_STEP_EN
  input  logic              step,
`endif
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              exec_valid,
  input  logic              dp_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [DATA_W-1:0] operand_out,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_JUMP  = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_OPER,
    S_EXEC,
    S_HALT,
    S_FAULT
`ifdef SEQ_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  logic [3:0]       fetch_op;

  function automatic logic is_two_byte(input logic [3:0] op);
    return op inside {OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_JUMP};
  endfunction

  assign fetch_op = mem_rdata[7:4];

  // The request that would be unacknowledged for the WAIT_MAX-th cycle.
  assign timeout = mem_req && !mem_ack && (wait_cnt == CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      exec_valid  <= 1'b0;
      instr_out   <= '0;
      operand_out <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      // mem_req is only ever high in FETCH/OPER, so this is the request age.
      if (mem_req) begin
        wait_cnt <= mem_ack ? '0 : wait_cnt + CNT_W'(1);
      end

      if (timeout) begin
        state   <= S_FAULT;
        mem_req <= 1'b0;
        busy    <= 1'b0;
        fault   <= 1'b1;
      end else begin
        case (state)
          S_IDLE, S_HALT: begin
            if (start) begin
              state    <= S_FETCH;
              mem_req  <= 1'b1;
              mem_addr <= pc;
              busy     <= 1'b1;
              halted   <= 1'b0;
            end
          end

          S_FETCH: begin
            if (!mem_req) begin
              // Gap cycle after a NOP; a stray ack here is ignored.
              mem_req  <= 1'b1;
              mem_addr <= pc;
            end else if (mem_ack) begin
              instr_out <= mem_rdata;
              pc        <= pc + ADDR_W'(1);
              if (is_two_byte(fetch_op)) begin
                // Keep requesting: operand read follows back to back.
                state    <= S_OPER;
                mem_addr <= pc + ADDR_W'(1);
              end else if (fetch_op == OP_STORE) begin
                state       <= S_EXEC;
                mem_req     <= 1'b0;
                operand_out <= '0;
                exec_valid  <= 1'b1;
              end else if (fetch_op == OP_HALT) begin
                state   <= S_HALT;
                mem_req <= 1'b0;
                busy    <= 1'b0;
                halted  <= 1'b1;
              end else begin
                mem_req <= 1'b0;
`ifdef SEQ_STEP_EN
                state <= S_PAUSE;
                busy  <= 1'b0;
`endif
              end
            end
          end

          S_OPER: begin
            if (mem_ack) begin
              if (instr_out[7:4] == OP_JUMP) begin
                pc <= ADDR_W'(mem_rdata);
`ifdef SEQ_STEP_EN
                state   <= S_PAUSE;
                mem_req <= 1'b0;
                busy    <= 1'b0;
`else
                state    <= S_FETCH;
                mem_addr <= ADDR_W'(mem_rdata);
`endif
              end else begin
                pc          <= pc + ADDR_W'(1);
                operand_out <= mem_rdata;
                state       <= S_EXEC;
                mem_req     <= 1'b0;
                exec_valid  <= 1'b1;
              end
            end
          end

          S_EXEC: begin
            if (dp_ready) begin
              exec_valid <= 1'b0;
`ifdef SEQ_STEP_EN
              state <= S_PAUSE;
              busy  <= 1'b0;
`else
              state    <= S_FETCH;
              mem_req  <= 1'b1;
              mem_addr <= pc;
`endif
            end
          end

`ifdef SEQ_STEP_EN
          S_PAUSE: begin
            if (step || start) begin
              state    <= S_FETCH;
              mem_req  <= 1'b1;
              mem_addr <= pc;
              busy     <= 1'b1;
            end
          end
`endif

          S_FAULT: begin
            // Sticky until reset.
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acc_fetch_sequencer.sv
// tb/tb_acc_fetch_sequencer.sv - self-checking bench for acc_fetch_sequencer
module tb_acc_fetch_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
`ifdef SEQ_STEP_EN
  logic       step;
`endif
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       exec_valid;
  logic       dp_ready;
  logic [7:0] instr_out;
  logic [7:0] operand_out;
  logic [7:0] pc;
  logic       busy;
  logic       halted;
  logic       fault;

  acc_fetch_sequencer #(.ADDR_W(8), .DATA_W(8), .WAIT_MAX(15)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .exec_valid(exec_valid),
    .dp_ready(dp_ready),
    .instr_out(instr_out),
    .operand_out(operand_out),
    .pc(pc),
    .busy(busy),
    .halted(halted),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  int          xfer_cyc [$];
  int          cyc = 0;
  int          xfer_cnt = 0;
  logic [7:0]  xfer_pc = 8'h00;
  int          req_wait = 0;
  int          cur_lat = 0;
  int          lat_max = 0;
  int          ready_mode = 1;   // 0 low, 1 high, 2 random
  int          ready_pct = 60;
  bit          ack_off = 1'b0;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0]  prev_addr = 8'h00, prev_instr = 8'h00, prev_opd = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: called at a falling edge, checks handshake rules, drives
  // memory/datapath inputs for the next rising edge, scores any transfer.
  task automatic cycle();
    logic [15:0] e;
    if (mem_req && prev_req && !prev_ack) check("addr_stable", mem_addr, prev_addr);
    if (exec_valid && prev_valid && !prev_ready) begin
      check("instr_stable", instr_out, prev_instr);
      check("operand_stable", operand_out, prev_opd);
    end
    if (mem_req && !ack_off && req_wait >= cur_lat) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
      req_wait  = 0;
      cur_lat   = $urandom_range(0, lat_max);
    end else begin
      if (mem_req) req_wait++;
      mem_ack   = !mem_req && ($urandom_range(0, 4) == 0);
      mem_rdata = 8'($urandom);
    end
    dp_ready = (ready_mode == 2) ? ($urandom_range(0, 99) < ready_pct) : (ready_mode == 1);
    if (exec_valid && dp_ready && !reset) begin
      check("xfer_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("xfer_data", {instr_out, operand_out}, e);
      end
      xfer_cyc.push_back(cyc);
      xfer_pc = pc;
      xfer_cnt++;
    end
    prev_req   = mem_req;
    prev_ack   = mem_ack;
    prev_addr  = mem_addr;
    prev_valid = exec_valid;
    prev_ready = dp_ready;
    prev_instr = instr_out;
    prev_opd   = operand_out;
`ifdef SEQ_STEP_EN
    step = 1'($urandom_range(0, 1));
`endif
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_checks();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_exec_valid", exec_valid, 0);
    check("rst_instr_out", instr_out, 0);
    check("rst_operand_out", operand_out, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    ready_mode = 0;
    cycle();
    reset = 1'b0;
    exp_q.delete();
    xfer_cyc.delete();
    req_wait = 0;
    cur_lat = 0;
    reset_checks();
  endtask

  task automatic go();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_to_halt(input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      cycle();
      done = halted;
    end
    check("halt_reached", halted, 1);
  endtask

  // Instruction-level interpreter: expected transfers and final pc.
  task automatic model_run(input logic [7:0] spc, output logic [7:0] fpc);
    logic [7:0] p, ins, opd;
    bit stop = 1'b0;
    p = spc;
    for (int n = 0; n < 1000 && !stop; n++) begin
      ins = mem[p];
      p = p + 8'd1;
      case (ins[7:4])
        4'h1, 4'h3, 4'h4, 4'h5, 4'h6: begin
          opd = mem[p];
          p = p + 8'd1;
          exp_q.push_back({ins, opd});
        end
        4'h7: p = mem[p];
        4'h2: exp_q.push_back({ins, 8'h00});
        4'hF: stop = 1'b1;
        default: ;
      endcase
    end
    fpc = p;
  endtask

  // Random program from address 0 with HALTs in the middle and at the end;
  // jumps only go forward over garbage bytes.
  task automatic gen_prog(input int n);
    logic [7:0] a;
    logic [3:0] op;
    int gap, r;
    a = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (i == n / 2 || i == n - 1) begin
        mem[a] = {4'hF, 4'($urandom)};
        a = a + 8'd1;
      end else begin
        case ($urandom_range(0, 3))
          0: begin
            r = $urandom_range(0, 4);
            op = (r == 0) ? 4'h1 : 4'(r + 2);
            mem[a] = {op, 4'($urandom)};
            mem[a + 8'd1] = 8'($urandom);
            a = a + 8'd2;
          end
          1: begin
            mem[a] = {4'h2, 4'($urandom)};
            a = a + 8'd1;
          end
          2: begin
            r = $urandom_range(0, 7);
            op = (r == 0) ? 4'h0 : 4'(r + 7);
            mem[a] = {op, 4'($urandom)};
            a = a + 8'd1;
          end
          default: begin
            gap = $urandom_range(0, 4);
            mem[a] = {4'h7, 4'($urandom)};
            mem[a + 8'd1] = a + 8'd2 + 8'(gap);
            a = a + 8'd2 + 8'(gap);
          end
        endcase
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  initial begin
    logic [7:0] f1, f2;
    int s, reqc, n0;
    reset = 1'b1;
    start = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    dp_ready = 1'b0;
`ifdef SEQ_STEP_EN
    step = 1'b0;
`endif
    @(negedge clk);

    // Straight-line program, zero-wait memory, datapath always ready.
    do_reset();
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h30;
    mem[3] = 8'h03; mem[4] = 8'h20; mem[5] = 8'hF0;
    exp_q.push_back(16'h1005);
    exp_q.push_back(16'h3003);
    exp_q.push_back(16'h2000);
    lat_max = 0;
    ready_mode = 1;
    s = cyc;
    go();
    run_to_halt(60);
    check("prog1_xfers", xfer_cyc.size(), 3);
    check("prog1_left", exp_q.size(), 0);
    check("prog1_pc", pc, 8'h06);
    check("prog1_busy", busy, 0);
    check("prog1_req", mem_req, 0);
`ifndef SEQ_STEP_EN
    if (xfer_cyc.size() == 3) begin
      check("lat_two_byte_first", xfer_cyc[0] - s, 3);
      check("lat_two_byte", xfer_cyc[1] - xfer_cyc[0], 3);
      check("lat_one_byte", xfer_cyc[2] - xfer_cyc[1], 2);
    end
`endif

    // JUMP is resolved internally.
    do_reset();
    clear_mem();
    mem[8'h00] = 8'h70; mem[8'h01] = 8'h80;
    mem[8'h80] = 8'h10; mem[8'h81] = 8'h2A; mem[8'h82] = 8'hF0;
    exp_q.push_back(16'h102A);
    lat_max = 3;
    ready_mode = 2;
    n0 = xfer_cnt;
    go();
    run_to_halt(200);
    check("jump_xfers", xfer_cnt - n0, 1);
    check("jump_xfer_pc", xfer_pc, 8'h82);
    check("jump_halt_pc", pc, 8'h83);

    // Backpressure for five cycles.
    do_reset();
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'h07; mem[2] = 8'hF0;
    exp_q.push_back(16'h3007);
    lat_max = 0;
    ready_mode = 0;
    go();
    for (int i = 0; i < 30 && !exec_valid; i++) cycle();
    check("bp_exec_seen", exec_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", exec_valid, 1);
      check("bp_no_req", mem_req, 0);
      check("bp_instr", instr_out, 8'h30);
      check("bp_operand", operand_out, 8'h07);
      cycle();
    end
    ready_mode = 1;
    n0 = xfer_cnt;
    cycle();
    check("bp_xfer_on_ready", xfer_cnt - n0, 1);
    check("bp_valid_drop", exec_valid, 0);
    run_to_halt(60);
    check("bp_halt_pc", pc, 8'h03);

    // Memory never acknowledges: fault after WAIT_MAX request cycles.
    do_reset();
    clear_mem();
    ack_off = 1'b1;
    ready_mode = 1;
    reqc = 0;
    go();
    for (int i = 0; i < 60 && !fault; i++) begin
      if (mem_req) reqc++;
      cycle();
    end
    check("to_req_cycles", reqc, 15);
    check("to_fault", fault, 1);
    check("to_req_low", mem_req, 0);
    check("to_busy", busy, 0);
    go();
    for (int i = 0; i < 3; i++) cycle();
    check("to_start_ignored_fault", fault, 1);
    check("to_start_ignored_req", mem_req, 0);
    ack_off = 1'b0;
    do_reset();

    // Operand fetch wraps from 0xFF to 0x00.
    clear_mem();
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h70; mem[8'h02] = 8'hFF; mem[8'hFF] = 8'h30;
    exp_q.push_back(16'h3001);
    exp_q.push_back(16'h3001);
    lat_max = 1;
    ready_mode = 1;
    n0 = xfer_cnt;
    go();
    for (int i = 0; i < 80 && xfer_cnt == n0; i++) cycle();
    check("wrap_xfer", xfer_cnt - n0, 1);
    check("wrap_pc", xfer_pc, 8'h01);

    // Reset in the middle of EXEC.
    ready_mode = 0;
    for (int i = 0; i < 80 && !exec_valid; i++) cycle();
    check("mid_exec_seen", exec_valid, 1);
    do_reset();

    // Reset in the middle of FETCH, then start again from address 0.
    ack_off = 1'b1;
    go();
    for (int i = 0; i < 3; i++) cycle();
    check("mid_fetch_req", mem_req, 1);
    check("mid_fetch_busy", busy, 1);
    do_reset();
    go();
    check("after_rst_req", mem_req, 1);
    check("after_rst_addr", mem_addr, 8'h00);
    ack_off = 1'b0;
    do_reset();

    // Random programs, random memory latency and backpressure, HALT/resume.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      gen_prog($urandom_range(6, 16));
      lat_max = $urandom_range(0, 4);
      cur_lat = 0;
      ready_mode = 2;
      ready_pct = $urandom_range(30, 90);
      model_run(8'h00, f1);
      go();
      run_to_halt(3000);
      check("rand_pc1", pc, f1);
      check("rand_left1", exp_q.size(), 0);
      model_run(f1, f2);
      go();
      run_to_halt(3000);
      check("rand_pc2", pc, f2);
      check("rand_left2", exp_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_fetch_sequencer.md
Name: acc_fetch_sequencer

Overview:
- Fetch/decode/execute controller for the 8-bit accumulator datapath.
- Fetches instruction bytes and operand bytes from program memory over a req/ack handshake, then presents one decoded operation per transfer to the datapath over a valid/ready handshake.
- Owns the program counter. Resolves JUMP and HALT internally, so the datapath only sees ALU/LOAD/STORE work.

Parameters:
- ADDR_W, 8, width of program counter and memory address.
- DATA_W, 8, width of instruction, operand and memory data.
- WAIT_MAX, 15, number of cycles a memory request may go unacknowledged before a fault is raised.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins or resumes execution from IDLE or HALT.
- mem_req  out  1  memory read request; held until mem_ack.
- mem_addr  out  ADDR_W  read address; stable while mem_req is high.
- mem_ack  in  1  read complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  read data.
- exec_valid  out  1  operation presented to the datapath.
- dp_ready  in  1  datapath accepts the operation.
- instr_out  out  DATA_W  instruction byte; stable while exec_valid is high.
- operand_out  out  DATA_W  operand byte (0 for single-byte instructions).
- pc  out  ADDR_W  current program counter.
- busy  out  1  high in every state except IDLE, HALT and FAULT.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-handshake): state=IDLE, pc=0, mem_req=0, mem_addr=0, exec_valid=0, instr_out=0, operand_out=0, busy=0, halted=0, fault=0, wait counter=0.
- Opcode is instr[7:4]:
  - 0x1 LOAD, 0x3 ADD, 0x4 SUB, 0x5 AND, 0x6 OR: two-byte instructions; operand is the next byte.
  - 0x2 STORE: one-byte instruction.
  - 0x7 JUMP: two-byte instruction; the next byte is the target address.
  - 0xF HALT.
  - All other opcodes are NOP: one byte, no datapath transfer.
- States: IDLE, FETCH, OPER, EXEC, HALT, FAULT.
- IDLE: when start=1, go to FETCH.
- FETCH:
  - mem_req=1, mem_addr=pc.
  - On mem_ack: latch instr, pc<=pc+1, then branch on opcode:
    - two-byte opcode -> OPER;
    - STORE -> EXEC with operand=0;
    - HALT -> HALT;
    - NOP -> stay in FETCH. mem_req drops for exactly one cycle between requests.
- OPER:
  - Same request at the new pc.
  - On mem_ack: latch operand, pc<=pc+1.
  - JUMP: pc<=operand (takes priority over the increment), then FETCH.
  - Otherwise -> EXEC.
- EXEC:
  - exec_valid=1 with instr_out and operand_out held stable.
  - Transfer happens on a cycle where exec_valid and dp_ready are both 1; the next cycle goes to FETCH with exec_valid=0.
  - dp_ready may already be high on entry: minimum EXEC duration is one cycle.
- Timing: minimum latency from instruction fetch to datapath transfer, with zero-wait memory:
  - 2 cycles for one-byte instructions;
  - 3 cycles for two-byte instructions.
- HALT: halted=1, pc points after the HALT byte. start=1 -> FETCH from that pc.
- Memory timeout:
  - The wait counter increments each cycle mem_req=1 and mem_ack=0, and clears on ack.
  - Reaching WAIT_MAX -> FAULT with mem_req=0.
  - FAULT: fault=1; the block stays in FAULT until reset, and start is ignored.
- start is ignored while busy.
- mem_ack while mem_req=0 is ignored.
- pc wraps from 2^ADDR_W-1 to 0. This applies to the operand fetch too.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro SEQ_STEP_EN.
- Defined:
  - Adds an input port step (1 bit).
  - After each completed EXEC transfer, each JUMP, and each NOP, the block enters state PAUSE (busy=0) instead of FETCH.
  - A step pulse in PAUSE -> FETCH.
  - start is also accepted in PAUSE and has the same effect as step.
- Not defined: no step port, no PAUSE state; the block runs continuously as described above.

Test Plan:
- Reset then start; memory holds 0x10,0x05,0x30,0x03,0x20,0xF0 with zero-wait ack -> exactly three transfers in order: (0x10,0x05), (0x30,0x03), (0x20,0x00); then halted=1 and pc=6.
- JUMP: memory holds 0x70,0x80 at address 0; 0x10,0x2A at 0x80 -> no exec_valid for the jump; next transfer is (0x10,0x2A) with pc=0x82 afterwards.
- Backpressure: dp_ready held low for 5 cycles during EXEC -> exec_valid stays high, instr_out and operand_out stable, no new mem_req; transfer occurs on the cycle dp_ready rises.
- Timeout: mem_ack never asserted -> fault=1 after WAIT_MAX=15 request cycles, mem_req=0; start has no effect; reset clears fault.
- Wrap: pc=0xFF holds 0x30 and address 0x00 holds 0x01 -> operand read from 0x00; transfer (0x30,0x01) and pc=0x01 afterwards.
- Reset asserted mid-EXEC and mid-FETCH -> on the next edge exec_valid=0, mem_req=0, pc=0, state IDLE.
